svm_window_feeder: RTL and testbench

//  Sequencer on the input side of svm_pe. Walks one HOG detection window block-by-block, reads
//  4-cell features and SVM coefficients from sync memories, feeds them to svm_pe, chains the

---
 rtl/svm_window_feeder.sv | 149 ++++++++++++++
 tb/tb_svm_window_feeder.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/svm_window_feeder.sv
// Walks one HOG window block-by-block through sync feature/coef memories into svm_pe and reports the score.
// Latency: start edge T -> o_done visible at T+NBLK+3; no backpressure, one block issued per cycle while running.
module svm_window_feeder #(
    parameter int FEA_I     = 4,
    parameter int FEA_F     = 28,
    parameter int WIN_BLK_W = 7,
    parameter int WIN_BLK_H = 15,
    parameter int IMG_BLK_W = 79,
    parameter int FADDR_W   = 13,
    parameter int CADDR_W   = 7,
    parameter logic [FEA_I+FEA_F-1:0] BIAS = '0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_start,
    input  logic [FADDR_W-1:0]              i_base_addr,
    output logic                            o_busy,
    output logic                            o_fea_rd,
    output logic [FADDR_W-1:0]              o_fea_addr,
    input  logic [36*(FEA_I+FEA_F)-1:0]     i_fea,
    output logic [CADDR_W-1:0]              o_coef_addr,
    input  logic [36*(FEA_I+FEA_F)-1:0]     i_coef,
    output logic [9*(FEA_I+FEA_F)-1:0]      o_fea_a,
    output logic [9*(FEA_I+FEA_F)-1:0]      o_fea_b,
    output logic [9*(FEA_I+FEA_F)-1:0]      o_fea_c,
    output logic [9*(FEA_I+FEA_F)-1:0]      o_fea_d,
    output logic [9*(FEA_I+FEA_F)-1:0]      o_coef_a,
    output logic [9*(FEA_I+FEA_F)-1:0]      o_coef_b,
    output logic [9*(FEA_I+FEA_F)-1:0]      o_coef_c,
    output logic [9*(FEA_I+FEA_F)-1:0]      o_coef_d,
    output logic [FEA_I+FEA_F-1:0]          o_pe_data,
    output logic                            o_pe_valid,
    input  logic [FEA_I+FEA_F-1:0]          i_pe_data,
    output logic [FEA_I+FEA_F-1:0]          o_score,
    output logic                            o_human,
    output logic                            o_done
);

    localparam int FEA_N = FEA_I + FEA_F;
    localparam int CELL_W = 9 * FEA_N;
    localparam int NBLK = WIN_BLK_W * WIN_BLK_H;
    localparam int COL_W = $clog2(WIN_BLK_W);
    localparam logic [COL_W-1:0]   COL_LAST = COL_W'(WIN_BLK_W - 1);
    localparam logic [CADDR_W-1:0] LAST_BLK = CADDR_W'(NBLK - 1);
    localparam logic [FADDR_W-1:0] ROW_STEP = FADDR_W'(IMG_BLK_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [COL_W-1:0]   col;
    logic [FADDR_W-1:0] row_base;
    logic               drain_cnt;
    logic               pe_first;

    assign o_busy = (state != IDLE);

    assign o_fea_a  = i_fea[0*CELL_W +: CELL_W];
    assign o_fea_b  = i_fea[1*CELL_W +: CELL_W];
    assign o_fea_c  = i_fea[2*CELL_W +: CELL_W];
    assign o_fea_d  = i_fea[3*CELL_W +: CELL_W];
    assign o_coef_a = i_coef[0*CELL_W +: CELL_W];
    assign o_coef_b = i_coef[1*CELL_W +: CELL_W];
    assign o_coef_c = i_coef[2*CELL_W +: CELL_W];
    assign o_coef_d = i_coef[3*CELL_W +: CELL_W];

    // The first block of a window seeds the chain with the bias instead of the stale PE sum.
    assign o_pe_data = pe_first ? BIAS : i_pe_data;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_start) state_nxt = RUN;
            RUN:     if (o_coef_addr == LAST_BLK) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            col         <= '0;
            row_base    <= '0;
            drain_cnt   <= 1'b0;
            pe_first    <= 1'b0;
            o_fea_rd    <= 1'b0;
            o_fea_addr  <= '0;
            o_coef_addr <= '0;
            o_pe_valid  <= 1'b0;
            o_score     <= '0;
            o_human     <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            o_done     <= 1'b0;
            o_pe_valid <= o_fea_rd;
            pe_first   <= o_fea_rd && (o_coef_addr == '0);
            case (state)
                IDLE: begin
                    if (i_start) begin
                        row_base    <= i_base_addr;
                        col         <= '0;
                        o_fea_addr  <= i_base_addr;
                        o_coef_addr <= '0;
                        o_fea_rd    <= 1'b1;
                    end
                end
                RUN: begin
                    if (o_coef_addr == LAST_BLK) begin
                        o_fea_rd  <= 1'b0;
                        drain_cnt <= 1'b0;
                    end else begin
                        o_coef_addr <= o_coef_addr + 1'b1;
                        if (col == COL_LAST) begin
                            col        <= '0;
                            row_base   <= row_base + ROW_STEP;
                            o_fea_addr <= row_base + ROW_STEP;
                        end else begin
                            col        <= col + 1'b1;
                            o_fea_addr <= o_fea_addr + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    drain_cnt <= 1'b1;
                    // Second drain cycle: the PE has registered the last block's sum.
                    if (drain_cnt) begin
                        o_score <= i_pe_data;
                        o_human <= !i_pe_data[FEA_N-1] && (i_pe_data != '0);
                        o_done  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_svm_window_feeder.sv
// Bench for svm_window_feeder: memory and svm_pe environment plus a window-level score model.
module tb_svm_window_feeder;

    localparam int NBLK = 105;
    localparam logic [31:0] BIAS_B = 32'h0800_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic i_start = 1'b0;
    logic [12:0] i_base_addr = '0;
    logic [1151:0] fea_q = '0;
    logic [1151:0] coef_q = '0;
    logic [31:0] pe_q0 = '0;
    logic [31:0] pe_q1 = '0;

    logic busy0, rd0, vld0, done0, human0;
    logic [12:0] faddr0;
    logic [6:0] caddr0;
    logic [287:0] fa0, fb0, fc0, fd0, ca0, cb0, cc0, cd0;
    logic [31:0] pdat0, score0;

    logic busy1, rd1, vld1, done1, human1;
    logic [12:0] faddr1;
    logic [6:0] caddr1;
    logic [287:0] fa1, fb1, fc1, fd1, ca1, cb1, cc1, cd1;
    logic [31:0] pdat1, score1;

    int checks = 0;
    int errors = 0;
    int fea_mode = 0;
    int coef_mode = 0;
    logic [31:0] seed = '0;

    int n_vld, first_vld, last_vld, busy_bad, pt_bad;
    int glitch_k = -1;
    int rst_k = -1;
    logic [12:0] glitch_base = '0;
    logic [12:0] addr_q[$];
    logic [6:0] caddr_q[$];

    always #5 clk = ~clk;

    svm_window_feeder u_dut0 (
        .clk(clk), .rst(rst), .i_start(i_start), .i_base_addr(i_base_addr),
        .o_busy(busy0), .o_fea_rd(rd0), .o_fea_addr(faddr0), .i_fea(fea_q),
        .o_coef_addr(caddr0), .i_coef(coef_q),
        .o_fea_a(fa0), .o_fea_b(fb0), .o_fea_c(fc0), .o_fea_d(fd0),
        .o_coef_a(ca0), .o_coef_b(cb0), .o_coef_c(cc0), .o_coef_d(cd0),
        .o_pe_data(pdat0), .o_pe_valid(vld0), .i_pe_data(pe_q0),
        .o_score(score0), .o_human(human0), .o_done(done0)
    );

    svm_window_feeder #(.BIAS(BIAS_B)) u_dut1 (
        .clk(clk), .rst(rst), .i_start(i_start), .i_base_addr(i_base_addr),
        .o_busy(busy1), .o_fea_rd(rd1), .o_fea_addr(faddr1), .i_fea(fea_q),
        .o_coef_addr(caddr1), .i_coef(coef_q),
        .o_fea_a(fa1), .o_fea_b(fb1), .o_fea_c(fc1), .o_fea_d(fd1),
        .o_coef_a(ca1), .o_coef_b(cb1), .o_coef_c(cc1), .o_coef_d(cd1),
        .o_pe_data(pdat1), .o_pe_valid(vld1), .i_pe_data(pe_q1),
        .o_score(score1), .o_human(human1), .o_done(done1)
    );

    function automatic logic [31:0] mix(input logic [31:0] x);
        logic [31:0] h;
        h = x ^ (x >> 15);
        h = h * 32'h2C1B_3C6D;
        return h ^ (h >> 13);
    endfunction

    function automatic logic [31:0] fea_word(input logic [12:0] a, input int i);
        case (fea_mode)
            0: return 32'h0;
            1: return 32'h1000_0000;
            default: return mix(({19'd0, a} * 32'h9E37_79B1) ^ (i * 32'h85EB_CA6B) ^ seed);
        endcase
    endfunction

    function automatic logic [31:0] coef_word(input logic [6:0] c, input int i);
        case (coef_mode)
            0: return 32'h0;
            1: return 32'h0001_0000;
            2: return 32'hFFFF_0000;
            default: return mix(({25'd0, c} * 32'h7FEB_352D) ^ (i * 32'h846C_A68B) ^ ~seed);
        endcase
    endfunction

    function automatic logic [1151:0] build_fea(input logic [12:0] a);
        logic [1151:0] v;
        for (int i = 0; i < 36; i++) v[i*32 +: 32] = fea_word(a, i);
        return v;
    endfunction

    function automatic logic [1151:0] build_coef(input logic [6:0] c);
        logic [1151:0] v;
        for (int i = 0; i < 36; i++) v[i*32 +: 32] = coef_word(c, i);
        return v;
    endfunction

    // svm_pe arithmetic: Q4.28 products truncated back to Q4.28, accumulated mod 2^32.
    function automatic logic [31:0] mac(input logic [31:0] acc, input logic [1151:0] f,
                                        input logic [1151:0] c);
        logic signed [63:0] p;
        logic [31:0] s;
        s = acc;
        for (int i = 0; i < 36; i++) begin
            p = $signed(f[i*32 +: 32]) * $signed(c[i*32 +: 32]);
            s = s + p[59:28];
        end
        return s;
    endfunction

    function automatic logic [31:0] model_score(input logic [12:0] base, input logic [31:0] bias);
        logic [31:0] s;
        s = bias;
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 7; c++)
                s = mac(s, build_fea(base + 13'(r * 79 + c)), build_coef(7'(r * 7 + c)));
        return s;
    endfunction

    always @(posedge clk) begin
        fea_q  <= build_fea(faddr0);
        coef_q <= build_coef(caddr0);
    end

    always @(posedge clk) begin
        if (!rst) begin
            pe_q0 <= '0;
            pe_q1 <= '0;
        end else begin
            if (vld0) pe_q0 <= mac(pdat0, {fd0, fc0, fb0, fa0}, {cd0, cc0, cb0, ca0});
            if (vld1) pe_q1 <= mac(pdat1, {fd1, fc1, fb1, fa1}, {cd1, cc1, cb1, ca1});
        end
    end

    // Called at a negedge; returns at the negedge of cycle T+1 with i_start released.
    task automatic start_win(input logic [12:0] base);
        i_start = 1'b1;
        i_base_addr = base;
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b0;
        i_base_addr = ~base;
    endtask

    // Observes one window from cycle T+1; done_k is the cycle o_done was seen, -1 on timeout.
    task automatic watch(output int done_k);
        done_k = -1;
        n_vld = 0;
        first_vld = -1;
        last_vld = -1;
        busy_bad = 0;
        pt_bad = 0;
        addr_q.delete();
        caddr_q.delete();
        for (int k = 1; k <= 300; k++) begin
            if (k == rst_k) begin
                rst = 1'b0;
                done_k = -2;
                return;
            end
            if (k == glitch_k) begin
                i_start = 1'b1;
                i_base_addr = glitch_base;
            end else if (k == glitch_k + 1) begin
                i_start = 1'b0;
            end
            if (rd0) begin
                addr_q.push_back(faddr0);
                caddr_q.push_back(caddr0);
            end
            if (vld0) begin
                n_vld++;
                if (first_vld < 0) first_vld = k;
                last_vld = k;
                if (fb0 !== fea_q[575:288] || cd0 !== coef_q[1151:864]) pt_bad++;
            end
            if (busy0 !== (k <= NBLK + 2)) busy_bad++;
            if (done0) begin
                done_k = k;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy0, rd0, vld0, done0, human0} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got busy/rd/vld/done/human=%b expected 00000",
                     {busy0, rd0, vld0, done0, human0});
        end
        checks++;
        if (score0 !== 32'h0 || faddr0 !== 13'h0 || caddr0 !== 7'h0) begin
            errors++;
            $display("FAIL reset_regs got score=%h faddr=%h caddr=%h expected 0", score0, faddr0, caddr0);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got busy=%b done=%b expected 0 0", busy0, done0);
        end
    endtask

    task automatic test_bias_only;
        int dk;
        fea_mode = 0;
        coef_mode = 0;
        start_win(13'd0);
        watch(dk);
        checks++;
        if (dk !== NBLK + 3) begin
            errors++;
            $display("FAIL bias_done_cycle got %0d expected %0d", dk, NBLK + 3);
        end
        checks++;
        if (score1 !== 32'h0800_0000 || human1 !== 1'b1) begin
            errors++;
            $display("FAIL bias_score got %h/%b expected 08000000/1", score1, human1);
        end
        checks++;
        if (score0 !== 32'h0 || human0 !== 1'b0) begin
            errors++;
            $display("FAIL zero_score_human got %h/%b expected 00000000/0", score0, human0);
        end
        checks++;
        if (busy_bad !== 0) begin
            errors++;
            $display("FAIL busy_window got %0d bad cycles expected 0", busy_bad);
        end
    endtask

    task automatic test_ones(input int cmode, input logic [31:0] exp0, input logic [31:0] exp1,
                             input logic exp_h);
        int dk;
        fea_mode = 1;
        coef_mode = cmode;
        start_win(13'd3);
        watch(dk);
        checks++;
        if (dk !== NBLK + 3 || score0 !== exp0 || human0 !== exp_h) begin
            errors++;
            $display("FAIL const_score mode=%0d got done=%0d score=%h human=%b expected %0d %h %b",
                     cmode, dk, score0, human0, NBLK + 3, exp0, exp_h);
        end
        checks++;
        if (score1 !== exp1) begin
            errors++;
            $display("FAIL const_score_bias mode=%0d got %h expected %h", cmode, score1, exp1);
        end
    endtask

    task automatic test_addr_seq;
        int dk;
        logic [12:0] ea;
        logic [31:0] exp;
        fea_mode = 2;
        coef_mode = 3;
        seed = $urandom;
        start_win(13'd10);
        watch(dk);
        checks++;
        if (addr_q.size() != NBLK || caddr_q.size() != NBLK) begin
            errors++;
            $display("FAIL strobe_count got %0d/%0d expected %0d", addr_q.size(), caddr_q.size(), NBLK);
        end else begin
            for (int j = 0; j < NBLK; j++) begin
                ea = 13'(10 + (j / 7) * 79 + (j % 7));
                checks++;
                if (addr_q[j] !== ea || caddr_q[j] !== 7'(j)) begin
                    errors++;
                    $display("FAIL addr_seq blk=%0d got fea=%0d coef=%0d expected %0d %0d",
                             j, addr_q[j], caddr_q[j], ea, j);
                end
            end
        end
        checks++;
        if (first_vld !== 2 || last_vld !== NBLK + 1 || n_vld !== NBLK) begin
            errors++;
            $display("FAIL pe_valid_window got first=%0d last=%0d n=%0d expected 2 %0d %0d",
                     first_vld, last_vld, n_vld, NBLK + 1, NBLK);
        end
        checks++;
        if (pt_bad !== 0) begin
            errors++;
            $display("FAIL passthrough got %0d bad cycles expected 0", pt_bad);
        end
        exp = model_score(13'd10, 32'h0);
        checks++;
        if (score0 !== exp) begin
            errors++;
            $display("FAIL addr_seq_score got %h expected %h", score0, exp);
        end
    endtask

    task automatic test_random;
        int dk;
        logic [12:0] base;
        logic [31:0] e0, e1;
        for (int it = 0; it < 4; it++) begin
            seed = $urandom;
            fea_mode = 2;
            coef_mode = 3;
            base = (it == 0) ? 13'd8150 : 13'($urandom_range(0, 8191));
            start_win(base);
            watch(dk);
            e0 = model_score(base, 32'h0);
            e1 = model_score(base, BIAS_B);
            checks++;
            if (dk !== NBLK + 3 || score0 !== e0 || human0 !== ($signed(e0) > 0)) begin
                errors++;
                $display("FAIL random_score base=%0d got done=%0d %h/%b expected %0d %h/%b",
                         base, dk, score0, human0, NBLK + 3, e0, $signed(e0) > 0);
            end
            checks++;
            if (score1 !== e1 || human1 !== ($signed(e1) > 0)) begin
                errors++;
                $display("FAIL random_score_bias base=%0d got %h/%b expected %h/%b",
                         base, score1, human1, e1, $signed(e1) > 0);
            end
        end
    endtask

    task automatic test_back_to_back;
        int dk;
        logic [31:0] ea, eb;
        seed = $urandom;
        fea_mode = 2;
        coef_mode = 3;
        ea = model_score(13'd200, 32'h0);
        eb = model_score(13'd4000, 32'h0);
        glitch_k = 50;
        glitch_base = 13'd4000;
        start_win(13'd200);
        watch(dk);
        glitch_k = -1;
        checks++;
        if (dk !== NBLK + 3 || score0 !== ea) begin
            errors++;
            $display("FAIL start_while_busy got done=%0d score=%h expected %0d %h", dk, score0, NBLK + 3, ea);
        end
        start_win(13'd4000);
        watch(dk);
        checks++;
        if (dk !== NBLK + 3 || score0 !== eb) begin
            errors++;
            $display("FAIL start_in_done got done=%0d score=%h expected %0d %h", dk, score0, NBLK + 3, eb);
        end
    endtask

    task automatic test_reset_mid;
        int dk;
        fea_mode = 1;
        coef_mode = 1;
        rst_k = 60;
        start_win(13'd77);
        watch(dk);
        rst_k = -1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy0, vld0, rd0, done0} !== 4'b0) begin
            errors++;
            $display("FAIL mid_reset_flags got busy/vld/rd/done=%b expected 0000", {busy0, vld0, rd0, done0});
        end
        checks++;
        if (score0 !== 32'h0 || human0 !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_score got %h/%b expected 00000000/0", score0, human0);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (done0 !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_no_done got %b expected 0", done0);
        end
        start_win(13'd5);
        watch(dk);
        checks++;
        if (dk !== NBLK + 3 || score0 !== 32'h0EC4_0000) begin
            errors++;
            $display("FAIL after_reset_window got done=%0d score=%h expected %0d 0ec40000",
                     dk, score0, NBLK + 3);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_bias_only();
        test_ones(1, 32'h0EC4_0000, 32'h16C4_0000, 1'b1);
        test_ones(2, 32'hF13C_0000, 32'hF93C_0000, 1'b0);
        test_addr_seq();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
